// File: rtl/lcd_timing_gen.sv
// Pixel-clock video timing generator: free-running h/v counters gated by PLL lock,
// pixel fetch requests, and a fixed-latency pipeline that aligns syncs/DE with returned RGB.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 2
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    input  logic [23:0] pix_rdata,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("lcd_timing_gen: RD_LAT must be within 1..4");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $error("lcd_timing_gen: porch and sync widths must be at least 1");
    end
    if (H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_bad_total
        $error("lcd_timing_gen: H_TOTAL must be <= 2047 and V_TOTAL <= 1023");
    end

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } ctl_t;

    logic        sync1;
    logic        lock_s;
    logic        run;
    logic        adv;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        act;
    logic        hs0;
    logic        vs0;
    logic        fs0;
    logic        hs_r;
    logic        vs_r;
    logic        fs_r;
    ctl_t        dly [RD_LAT];
    ctl_t        tail;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_locked;
            lock_s <= sync1;
        end
    end

    assign run = ~rst & lock_s;
    // Looking one flop earlier lets everything clear on the same edge lock_s drops,
    // so the block is fully idle by the time run reads 0.
    assign adv = run & sync1;

    always_ff @(posedge refclk) begin
        if (!adv) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs0 = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs0 = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign fs0 = (h_cnt == 11'd0) && (v_cnt == 10'd0);

    always_ff @(posedge refclk) begin
        if (!adv) begin
            pix_req <= 1'b0;
            pix_x   <= '0;
            pix_y   <= '0;
            hs_r    <= 1'b0;
            vs_r    <= 1'b0;
            fs_r    <= 1'b0;
        end else begin
            pix_req <= act;
            pix_x   <= act ? h_cnt : 11'd0;
            pix_y   <= act ? v_cnt : 10'd0;
            hs_r    <= hs0;
            vs_r    <= vs0;
            fs_r    <= fs0;
        end
    end

    // Delay the control bits by the memory read latency so they meet pix_rdata.
    always_ff @(posedge refclk) begin
        if (!adv) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= '{de: pix_req, hs: hs_r, vs: vs_r, fs: fs_r};
            for (int i = 1; i < RD_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tail = dly[RD_LAT-1];

    always_ff @(posedge refclk) begin
        if (!adv) begin
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            vga_de      <= tail.de;
            vga_rgb     <= tail.de ? pix_rdata : 24'd0;
            vga_hs      <= tail.hs ? HS_POL : ~HS_POL;
            vga_vs      <= tail.vs ? VS_POL : ~VS_POL;
            frame_start <= tail.fs;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a reduced raster so several frames fit
// in a short run; a position-based reference model is compared every cycle.
module tb_lcd_timing_gen;

    localparam int HA = 16, HFP = 3, HSY = 5, HBP = 4;
    localparam int VA = 6, VFP = 2, VSY = 2, VBP = 3;
    localparam int LAT = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b1;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rdata = 24'd0;
    logic        frame_start;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [23:0] vga_rgb;

    int vectors = 0;
    int miscompares = 0;

    always #5 refclk = ~refclk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(LAT)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pix_req(pix_req),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_rdata(pix_rdata),
        .frame_start(frame_start),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_de(vga_de),
        .vga_rgb(vga_rgb)
    );

    // Frame memory: data for a request is valid only in the cycle LAT cycles later;
    // every other cycle carries noise so a misaligned or ungated capture shows up.
    logic [23:0] mem_data [LAT+1];
    bit          mem_vld  [LAT+1];

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            mem_data[i] = 24'd0;
            mem_vld[i]  = 1'b0;
        end
        forever begin
            @(negedge refclk);
            for (int i = LAT; i > 0; i--) begin
                mem_data[i] = mem_data[i-1];
                mem_vld[i]  = mem_vld[i-1];
            end
            mem_vld[0]  = (pix_req === 1'b1);
            mem_data[0] = {pix_x[7:0], pix_y[7:0], 8'hA5};
            pix_rdata   = mem_vld[LAT] ? mem_data[LAT] : 24'($urandom);
        end
    end

    // Reference: 'streak' is the number of consecutive edges on which the block was
    // allowed to advance; the raster position follows from it by plain arithmetic.
    bit     m_s1 = 1'b0;
    bit     m_ls = 1'b0;
    longint streak = 0;

    initial begin
        bit     en;
        int     p, h, v, qh, qv;
        bit     e_req, e_de, e_hs, e_vs, e_fs;
        int     e_x, e_y;
        logic [23:0] e_rgb;
        forever begin
            @(posedge refclk);
            en     = !rst && m_ls && m_s1;
            m_ls   = rst ? 1'b0 : m_s1;
            m_s1   = rst ? 1'b0 : pll_locked;
            streak = en ? streak + 1 : 0;
            #1;
            e_req = 0; e_x = 0; e_y = 0;
            if (streak >= 1) begin
                p  = int'((streak - 1) % FRAME);
                qh = p % HT;
                qv = p / HT;
                if (qh < HA && qv < VA) begin
                    e_req = 1; e_x = qh; e_y = qv;
                end
            end
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = 24'd0;
            if (streak >= LAT + 2) begin
                p    = int'((streak - LAT - 2) % FRAME);
                h    = p % HT;
                v    = p / HT;
                e_de = (h < HA) && (v < VA);
                e_hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
                e_vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
                e_fs = (h == 0) && (v == 0);
                if (e_de) e_rgb = {8'(h), 8'(v), 8'hA5};
            end
            vectors++;
            if (pix_req !== e_req || pix_x !== 11'(e_x) || pix_y !== 10'(e_y) ||
                vga_de !== e_de || vga_hs !== e_hs || vga_vs !== e_vs ||
                frame_start !== e_fs || vga_rgb !== e_rgb) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got req=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b rgb=%h need req=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b rgb=%h",
                         $time, pix_req, pix_x, pix_y, vga_de, vga_hs, vga_vs, frame_start, vga_rgb,
                         e_req, e_x, e_y, e_de, e_hs, e_vs, e_fs, e_rgb);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int need);
        vectors++;
        if (got != need) begin
            miscompares++;
            $display("FAIL %s got %0d need %0d", name, got, need);
        end
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0:       return pix_req === 1'b1;
            1:       return vga_de === 1'b1;
            2:       return vga_hs === 1'b1;
            3:       return vga_vs === 1'b1;
            4:       return frame_start === 1'b1;
            default: return (pix_req === 1'b1) && (pix_x == 11'd10) && (pix_y == 10'd3);
        endcase
    endfunction

    task automatic cycles_until(input int sel, input bit lvl, input int budget, output int n);
        n = 0;
        while (sig(sel) != lvl && n < budget) begin
            @(posedge refclk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n, de_cnt, vs_cnt, vs_first, fs_cnt, r, len;

        repeat (5) @(posedge refclk);
        #1;
        check_lit("reset_hs", int'(vga_hs), 1);
        check_lit("reset_vs", int'(vga_vs), 1);
        check_lit("reset_de", int'(vga_de), 0);
        check_lit("reset_rgb", int'(vga_rgb), 0);
        check_lit("reset_req", int'(pix_req), 0);

        @(negedge refclk);
        rst = 1'b0;
        cycles_until(0, 1'b1, 20, n);
        check_lit("first_req_delay", n, 3);
        check_lit("first_req_x", int'(pix_x), 0);
        check_lit("first_req_y", int'(pix_y), 0);
        cycles_until(1, 1'b1, 20, n);
        check_lit("first_de_delay", n, LAT + 1);
        check_lit("first_de_frame_start", int'(frame_start), 1);

        cycles_until(1, 1'b0, 100, n);
        check_lit("de_run", n, HA);
        cycles_until(2, 1'b0, 100, n);
        check_lit("front_porch", n, HFP);
        cycles_until(2, 1'b1, 100, n);
        check_lit("hsync_width", n, HSY);
        cycles_until(1, 1'b1, 100, n);
        check_lit("back_porch", n, HBP);

        cycles_until(4, 1'b1, FRAME + 50, n);
        check_lit("frame_sync_found", int'(frame_start), 1);
        de_cnt = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (vga_de) de_cnt++;
            if (frame_start) fs_cnt++;
            if (!vga_vs) begin
                if (vs_first < 0) vs_first = i;
                vs_cnt++;
            end
            @(posedge refclk);
            #1;
        end
        check_lit("frame_de_count", de_cnt, HA * VA);
        check_lit("frame_vs_cycles", vs_cnt, VSY * HT);
        check_lit("frame_vs_start", vs_first, (VA + VFP) * HT);
        check_lit("frame_fs_count", fs_cnt, 1);
        check_lit("frame_period", int'(frame_start), 1);

        cycles_until(5, 1'b1, FRAME + 50, n);
        check_lit("lock_drop_point", int'(sig(5)), 1);
        @(negedge refclk);
        pll_locked = 1'b0;
        check_lit("lock_drop_de_before", int'(vga_de), 1);
        repeat (2) @(posedge refclk);
        #1;
        check_lit("lock_drop_de", int'(vga_de), 0);
        check_lit("lock_drop_req", int'(pix_req), 0);
        check_lit("lock_drop_hs", int'(vga_hs), 1);
        repeat (8) @(negedge refclk);
        pll_locked = 1'b1;
        cycles_until(4, 1'b1, 30, n);
        check_lit("relock_frame_start", n, LAT + 4);
        check_lit("relock_rgb", int'(vga_rgb), int'({8'd0, 8'd0, 8'hA5}));

        for (int c = 0; c < 5000; c++) begin
            @(negedge refclk);
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                len = int'($urandom_range(1, 12));
                pll_locked = 1'b0;
                repeat (len) @(negedge refclk);
                pll_locked = 1'b1;
            end else if (r < 5) begin
                len = int'($urandom_range(1, 4));
                rst = 1'b1;
                repeat (len) @(negedge refclk);
                rst = 1'b0;
            end
        end

        repeat (10) @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
